ocp_mem_responder: RTL and testbench



---
 rtl/ocp_mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_ocp_mem_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_mem_responder.sv
// OCP responder backed by a word-addressed register memory.
//
// Accepts one command at a time from a single initiator and returns a registered
// response in the cycle after acceptance. Supports the RDL/WRC reservation pair.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   MCmd         request command (0 = IDLE)
//   MAddr        byte address
//   MData        write data
//   MByteEn      write byte enables
//   SCmdAccept   command accepted this cycle (combinational)
//   SResp        response code (NULL/DVA/FAIL/ERR)
//   SData        read data (0 for non-read responses)
//   MRespAccept  initiator takes the response

module ocp_mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              MCmd,
  input  logic [ADDR_WIDTH-1:0]   MAddr,
  input  logic [DATA_WIDTH-1:0]   MData,
  input  logic [DATA_WIDTH/8-1:0] MByteEn,
  output logic                    SCmdAccept,
  output logic [1:0]              SResp,
  output logic [DATA_WIDTH-1:0]   SData,
  input  logic                    MRespAccept
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Off      = (NumBytes > 1) ? $clog2(NumBytes) : 0;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("ocp_mem_responder: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH == 0) begin : g_bad_depth
    $error("ocp_mem_responder: DEPTH must be at least 1");
  end

  typedef enum logic [2:0] {
    CmdIdle = 3'd0,
    CmdWr   = 3'd1,
    CmdRd   = 3'd2,
    CmdRdex = 3'd3,
    CmdRdl  = 3'd4,
    CmdWrnp = 3'd5,
    CmdWrc  = 3'd6,
    CmdBcst = 3'd7
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    RespNull = 2'd0,
    RespDva  = 2'd1,
    RespFail = 2'd2,
    RespErr  = 2'd3
  } ocp_resp_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  resp_pending_q, resp_pending_d;
  ocp_resp_e             sresp_q, sresp_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  res_valid_q, res_valid_d;
  logic [IdxW-1:0]       res_idx_q, res_idx_d;

  ocp_cmd_e              cmd;
  logic [ADDR_WIDTH-1:0] idx;
  logic [IdxW-1:0]       widx;
  logic                  in_range;
  logic                  xfer;
  logic                  res_match;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  mem_we;

  assign cmd       = ocp_cmd_e'(MCmd);
  assign idx       = MAddr >> Off;
  assign widx      = idx[IdxW-1:0];
  assign in_range  = idx < ADDR_WIDTH'(DEPTH);
  assign rdata     = mem[widx];
  assign res_match = res_valid_q && (res_idx_q == widx);

  assign SCmdAccept = !reset && (!resp_pending_q || MRespAccept);
  assign xfer       = (cmd != CmdIdle) && SCmdAccept;

  assign SResp = sresp_q;
  assign SData = sdata_q;

  always_comb begin
    resp_pending_d = resp_pending_q;
    sresp_d        = sresp_q;
    sdata_d        = sdata_q;
    res_valid_d    = res_valid_q;
    res_idx_d      = res_idx_q;
    mem_we         = 1'b0;

    // Merge enabled bytes over the current word so the array is written whole.
    wdata = rdata;
    for (int b = 0; b < NumBytes; b++) begin
      if (MByteEn[b]) begin
        wdata[8*b +: 8] = MData[8*b +: 8];
      end
    end

    if (resp_pending_q && MRespAccept) begin
      resp_pending_d = 1'b0;
      sresp_d        = RespNull;
      sdata_d        = '0;
    end

    // A new response overrides the retire above, giving back-to-back responses.
    if (xfer) begin
      if (!in_range) begin
        resp_pending_d = 1'b1;
        sresp_d        = RespErr;
        sdata_d        = '0;
      end else begin
        unique case (cmd)
          CmdWr: begin
            mem_we = 1'b1;
            if (res_match) res_valid_d = 1'b0;
          end
          CmdWrnp: begin
            mem_we         = 1'b1;
            if (res_match) res_valid_d = 1'b0;
            resp_pending_d = 1'b1;
            sresp_d        = RespDva;
            sdata_d        = '0;
          end
          CmdRd: begin
            resp_pending_d = 1'b1;
            sresp_d        = RespDva;
            sdata_d        = rdata;
          end
          CmdRdl: begin
            resp_pending_d = 1'b1;
            sresp_d        = RespDva;
            sdata_d        = rdata;
            res_valid_d    = 1'b1;
            res_idx_d      = widx;
          end
          CmdWrc: begin
            res_valid_d    = 1'b0;
            resp_pending_d = 1'b1;
            sdata_d        = '0;
            if (res_match) begin
              mem_we  = 1'b1;
              sresp_d = RespDva;
            end else begin
              sresp_d = RespFail;
            end
          end
          CmdRdex, CmdBcst: begin
            resp_pending_d = 1'b1;
            sresp_d        = RespErr;
            sdata_d        = '0;
          end
          CmdIdle: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_pending_q <= 1'b0;
      sresp_q        <= RespNull;
      sdata_q        <= '0;
      res_valid_q    <= 1'b0;
      res_idx_q      <= '0;
    end else begin
      resp_pending_q <= resp_pending_d;
      sresp_q        <= sresp_d;
      sdata_q        <= sdata_d;
      res_valid_q    <= res_valid_d;
      res_idx_q      <= res_idx_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[widx] <= wdata;
    end
  end

endmodule

// File: tb/tb_ocp_mem_responder.sv
module tb_ocp_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2, RDEX = 3'd3;
  localparam logic [2:0] RDL = 3'd4, WRNP = 3'd5, WRC = 3'd6, BCST = 3'd7;
  localparam logic [1:0] RNULL = 2'd0, DVA = 2'd1, RFAIL = 2'd2, ERR = 2'd3;

  logic          clk;
  logic          reset;
  logic [2:0]    MCmd;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MData;
  logic [3:0]    MByteEn;
  logic          SCmdAccept;
  logic [1:0]    SResp;
  logic [DW-1:0] SData;
  logic          MRespAccept;

  ocp_mem_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MCmd       (MCmd),
    .MAddr      (MAddr),
    .MData      (MData),
    .MByteEn    (MByteEn),
    .SCmdAccept (SCmdAccept),
    .SResp      (SResp),
    .SData      (SData),
    .MRespAccept(MRespAccept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_res_valid;
  int          ref_res_idx;
  bit          m_pending;
  int          compared;
  int          mismatched;
  int          cyc;

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input logic [1:0] r, input logic [31:0] d);
    exp_t e;
    e.resp = r;
    e.data = d;
    e.cyc  = cyc;
    expq.push_back(e);
  endfunction

  function automatic void wr_bytes(input int idx, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // Reference behaviour of one accepted command; returns 1 if a response is produced.
  function automatic bit model(input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be);
    int idx;
    idx = int'(a >> 2);
    if (idx >= DEPTH) begin
      push(ERR, 32'd0);
      return 1'b1;
    end
    case (c)
      WR: begin
        wr_bytes(idx, d, be);
        if (ref_res_valid && ref_res_idx == idx) ref_res_valid = 1'b0;
        return 1'b0;
      end
      WRNP: begin
        wr_bytes(idx, d, be);
        if (ref_res_valid && ref_res_idx == idx) ref_res_valid = 1'b0;
        push(DVA, 32'd0);
      end
      RD: push(DVA, ref_mem[idx]);
      RDL: begin
        push(DVA, ref_mem[idx]);
        ref_res_valid = 1'b1;
        ref_res_idx   = idx;
      end
      WRC: begin
        if (ref_res_valid && ref_res_idx == idx) begin
          wr_bytes(idx, d, be);
          push(DVA, 32'd0);
        end else begin
          push(RFAIL, 32'd0);
        end
        ref_res_valid = 1'b0;
      end
      default: push(ERR, 32'd0);
    endcase
    return 1'b1;
  endfunction

  // One bus cycle: drive inputs, check acceptance against the model, update the model.
  task automatic cycle(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit racc, output bit acc);
    bit exp_acc;
    bit produced;
    @(posedge clk);
    #1;
    MCmd        = c;
    MAddr       = a;
    MData       = d;
    MByteEn     = be;
    MRespAccept = racc;
    #1;
    exp_acc = !m_pending || racc;
    compared++;
    if (SCmdAccept !== exp_acc) begin
      mismatched++;
      $display("FAIL accept: cyc %0d SCmdAccept=%b expected %b", cyc, SCmdAccept, exp_acc);
    end
    acc      = (c != IDLE) && exp_acc;
    produced = 1'b0;
    if (acc) produced = model(c, a, d, be);
    m_pending = produced || (m_pending && !racc);
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    bit acc;
    cycle(c, a, d, be, 1'b1, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(IDLE, 32'd0, 32'd0, 4'h0, 1'b1, acc);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    MCmd        = IDLE;
    MRespAccept = 1'b1;
    expq.delete();
    ref_res_valid = 1'b0;
    m_pending     = 1'b0;
    #1;
    compared++;
    if (SCmdAccept !== 1'b0) begin
      mismatched++;
      $display("FAIL accept_in_reset: SCmdAccept=%b expected 0", SCmdAccept);
    end
    repeat (n) @(posedge clk);
    #1;
    reset       = 1'b0;
    MRespAccept = 1'b0;
    #1;
    compared++;
    if (SResp !== RNULL || SData !== 32'd0 || SCmdAccept !== 1'b1) begin
      mismatched++;
      $display("FAIL after_reset: SResp=%0d SData=%h SCmdAccept=%b expected 0/00000000/1",
               SResp, SData, SCmdAccept);
    end
  endtask

  // Monitor: a response is due from the cycle after its command was accepted.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        compared++;
        if (SResp !== expq[0].resp || SData !== expq[0].data) begin
          mismatched++;
          $display("FAIL response: cyc %0d got %0d/%h expected %0d/%h",
                   cyc, SResp, SData, expq[0].resp, expq[0].data);
        end
        if (MRespAccept) void'(expq.pop_front());
      end else begin
        compared++;
        if (SResp !== RNULL || SData !== 32'd0) begin
          mismatched++;
          $display("FAIL no_response: cyc %0d got %0d/%h expected 0/00000000",
                   cyc, SResp, SData);
        end
      end
    end
  end

  initial begin
    #1000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [2:0]  rc;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  rb;
    int          ridx;

    reset       = 1'b1;
    MCmd        = IDLE;
    MAddr       = '0;
    MData       = '0;
    MByteEn     = '0;
    MRespAccept = 1'b0;
    ref_res_valid = 1'b0;
    ref_res_idx   = 0;
    m_pending     = 1'b0;

    do_reset(3);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) issue(WRNP, 32'(i * 4), $urandom, 4'hF);
    idle(2);

    // Write / read, partial byte write, zero byte enables.
    issue(WRNP, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(RD,   32'h10, 32'h0, 4'h0);
    issue(WR,   32'h10, 32'h000000AA, 4'h1);
    issue(RD,   32'h10, 32'h0, 4'h0);
    issue(WRNP, 32'h14, 32'h12345678, 4'h0);
    issue(RD,   32'h14, 32'h0, 4'h0);
    idle(2);

    // Backpressure: held response, then back-to-back replacement.
    cycle(RD, 32'h10, 32'h0, 4'h0, 1'b0, acc);
    repeat (5) cycle(RD, 32'h14, 32'h0, 4'h0, 1'b0, acc);
    cycle(RD, 32'h14, 32'h0, 4'h0, 1'b1, acc);
    idle(2);

    // Reservation success then failure.
    issue(RDL, 32'h20, 32'h0, 4'h0);
    issue(WRC, 32'h20, 32'h1, 4'hF);
    issue(WRC, 32'h20, 32'h2, 4'hF);
    issue(RD,  32'h20, 32'h0, 4'h0);
    // Reservation clearing.
    issue(RDL, 32'h20, 32'h0, 4'h0);
    issue(WR,  32'h20, 32'h5, 4'hF);
    issue(WRC, 32'h20, 32'h6, 4'hF);
    issue(RDL, 32'h20, 32'h0, 4'h0);
    issue(WRC, 32'h24, 32'h7, 4'hF);
    issue(WRC, 32'h20, 32'h8, 4'hF);
    issue(RDL, 32'h20, 32'h0, 4'h0);
    issue(RD,  32'h20, 32'h0, 4'h0);
    issue(WRC, 32'h20, 32'h9, 4'hF);
    issue(RD,  32'h20, 32'h0, 4'h0);
    idle(2);

    // Errors: out of range, unsupported commands; word 0 must not be aliased.
    issue(RD,   32'h400, 32'h0, 4'h0);
    issue(WR,   32'h400, 32'hCAFEF00D, 4'hF);
    issue(RD,   32'h0,   32'h0, 4'h0);
    issue(RDEX, 32'h0,   32'h0, 4'h0);
    issue(BCST, 32'h0,   32'h11111111, 4'hF);
    issue(RD,   32'h0,   32'h0, 4'h0);
    idle(2);

    // Reset while a response is held; reservation is lost.
    issue(RDL, 32'h20, 32'h0, 4'h0);
    cycle(RD, 32'h20, 32'h0, 4'h0, 1'b0, acc);
    do_reset(1);
    issue(WRC, 32'h20, 32'h3, 4'hF);
    issue(RD,  32'h20, 32'h0, 4'h0);
    idle(2);

    // Random traffic; an unaccepted command is held until accepted.
    rc  = IDLE;
    ra  = '0;
    rd  = '0;
    rb  = '0;
    acc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (acc || rc == IDLE) begin
        rc   = 3'($urandom_range(0, 7));
        ridx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 300))
                                           : int'($urandom_range(0, 5));
        ra   = 32'(ridx * 4) + 32'($urandom_range(0, 3));
        rd   = $urandom;
        rb   = 4'($urandom_range(0, 15));
      end
      cycle(rc, ra, rd, rb, ($urandom_range(0, 3) != 0), acc);
    end
    idle(4);

    @(posedge clk);
    #1;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d responses outstanding, expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
